// File: rtl/quad_encoder_counter.sv
// Quadrature encoder position counter: per-channel A/B decode with x1/x2/x4 resolution.
// Latency: input stable before edge k -> o_step pulse and count update at edge k+2.
// Backpressure: none; every counted step is reported as a one-cycle o_step pulse.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_phase_a/i_phase_b  asynchronous encoder phases, bit n = channel n
//   i_mode               00 = x1, 01 = x2, 10/11 = x4
//   i_cnt_clr            per-channel level-sensitive count clear
//   i_err_clr            clears all sticky error flags
//   o_step/o_dir         step pulse and direction of last step (1 = CW)
//   o_count              signed position, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//   o_err                sticky illegal-transition flag per channel
module quad_encoder_counter #(
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 16,
  parameter int WRAP      = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [CHANNELS-1:0]             i_phase_a,
  input  logic [CHANNELS-1:0]             i_phase_b,
  input  logic [1:0]                      i_mode,
  input  logic [CHANNELS-1:0]             i_cnt_clr,
  input  logic                            i_err_clr,
  output logic [CHANNELS-1:0]             o_step,
  output logic [CHANNELS-1:0]             o_dir,
  output logic [CHANNELS*CNT_WIDTH-1:0]   o_count,
  output logic [CHANNELS-1:0]             o_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Per-channel {A,B} pairs
  logic [CHANNELS-1:0][1:0]           sync1_q, sync2_q;
  logic [CHANNELS-1:0][1:0]           prev_q, prev_d;
  logic [CHANNELS-1:0][1:0]           leave_q, leave_d;
  logic [CHANNELS-1:0]                leave_vld_q, leave_vld_d;
  logic [CHANNELS-1:0]                step_q, step_d;
  logic [CHANNELS-1:0]                dir_q, dir_d;
  logic [CHANNELS-1:0]                err_q, err_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]                         mode_q;
  logic [1:0]                         start_q, start_d;

  logic                               decode_en;
  logic                               mode_chg;
  logic [CHANNELS-1:0]                qstep, illegal, cw, cnt_en;

  // Decode is held off until P has been loaded from a settled synchronizer.
  assign decode_en = (start_q == 2'd3);
  assign mode_chg  = (i_mode != mode_q);
  assign start_d   = decode_en ? start_q : start_q + 2'd1;

  always_comb begin
    prev_d      = prev_q;
    leave_d     = leave_q;
    leave_vld_d = leave_vld_q;
    step_d      = '0;
    dir_d       = dir_q;
    err_d       = err_q & ~{CHANNELS{i_err_clr}};
    cnt_d       = cnt_q;
    qstep       = '0;
    illegal     = '0;
    cw          = '0;
    cnt_en      = '0;

    for (int ch = 0; ch < CHANNELS; ch++) begin
      qstep[ch]   = decode_en && ((sync2_q[ch] ^ prev_q[ch]) == 2'b01 ||
                                  (sync2_q[ch] ^ prev_q[ch]) == 2'b10);
      illegal[ch] = decode_en && ((sync2_q[ch] ^ prev_q[ch]) == 2'b11);
      // Along 00->10->11->01->00 the old B bit always differs from the new A bit.
      cw[ch]      = prev_q[ch][0] ^ sync2_q[ch][1];

      unique case (i_mode)
        2'b00: begin
          // Full cycle only if we re-enter 00 from the side opposite the exit.
          cnt_en[ch] = qstep[ch] && (sync2_q[ch] == 2'b00) && leave_vld_q[ch] &&
                       (prev_q[ch] == ~leave_q[ch]);
        end
        2'b01:   cnt_en[ch] = qstep[ch] && (sync2_q[ch] == 2'b00 || sync2_q[ch] == 2'b11);
        default: cnt_en[ch] = qstep[ch];
      endcase

      // x1 leave tracking
      if (qstep[ch] && prev_q[ch] == 2'b00) begin
        leave_d[ch]     = sync2_q[ch];
        leave_vld_d[ch] = 1'b1;
      end
      if ((qstep[ch] && sync2_q[ch] == 2'b00) || illegal[ch] || mode_chg || !decode_en) begin
        leave_vld_d[ch] = 1'b0;
      end

      prev_d[ch] = sync2_q[ch];

      if (illegal[ch]) begin
        err_d[ch] = 1'b1;
      end

      if (cnt_en[ch]) begin
        step_d[ch] = 1'b1;
        dir_d[ch]  = cw[ch];
        if (cw[ch]) begin
          if (WRAP != 0 || cnt_q[ch] != CNT_MAX) begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
          end
        end else begin
          if (WRAP != 0 || cnt_q[ch] != CNT_MIN) begin
            cnt_d[ch] = cnt_q[ch] - CNT_ONE;
          end
        end
      end

      // Clear overrides the count but not the step report.
      if (i_cnt_clr[ch]) begin
        cnt_d[ch] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      leave_q     <= '0;
      leave_vld_q <= '0;
      step_q      <= '0;
      dir_q       <= '0;
      err_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= 2'b00;
      start_q     <= 2'd0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        sync1_q[ch] <= {i_phase_a[ch], i_phase_b[ch]};
      end
      sync2_q     <= sync1_q;
      prev_q      <= prev_d;
      leave_q     <= leave_d;
      leave_vld_q <= leave_vld_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      mode_q      <= i_mode;
      start_q     <= start_d;
    end
  end

  assign o_step  = step_q;
  assign o_dir   = dir_q;
  assign o_err   = err_q;
  assign o_count = cnt_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter: a 2-channel 16-bit instance plus
// two 1-channel 4-bit instances (wrap and saturate) fed from channel 0's phases.
module tb_quad_encoder_counter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pa, pb, mode, cnt_clr;
  logic        err_clr;
  logic        zero1;

  logic [1:0]  step, dir, err;
  logic [31:0] count;
  logic        step_w, dir_w, err_w;
  logic [3:0]  count_w;
  logic        step_s, dir_s, err_s;
  logic [3:0]  count_s;

  int tests = 0;
  int fails = 0;
  int p0 = 0, p1 = 0, pw = 0, ps = 0;
  int b0, b1, bw, bs;

  quad_encoder_counter #(.CHANNELS(2), .CNT_WIDTH(16), .WRAP(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_phase_a(pa), .i_phase_b(pb), .i_mode(mode),
    .i_cnt_clr(cnt_clr), .i_err_clr(err_clr),
    .o_step(step), .o_dir(dir), .o_count(count), .o_err(err)
  );

  quad_encoder_counter #(.CHANNELS(1), .CNT_WIDTH(4), .WRAP(1)) dut_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_phase_a(pa[0]), .i_phase_b(pb[0]), .i_mode(mode),
    .i_cnt_clr(zero1), .i_err_clr(err_clr),
    .o_step(step_w), .o_dir(dir_w), .o_count(count_w), .o_err(err_w)
  );

  quad_encoder_counter #(.CHANNELS(1), .CNT_WIDTH(4), .WRAP(0)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_phase_a(pa[0]), .i_phase_b(pb[0]), .i_mode(mode),
    .i_cnt_clr(zero1), .i_err_clr(err_clr),
    .o_step(step_s), .o_dir(dir_s), .o_count(count_s), .o_err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step pulse tallies, sampled on the falling edge.
  always @(negedge clk) begin
    if (step[0]) p0 <= p0 + 1;
    if (step[1]) p1 <= p1 + 1;
    if (step_w)  pw <= pw + 1;
    if (step_s)  ps <= ps + 1;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [1:0] st);
    pa[0] = st[1];
    pb[0] = st[0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    zero1   = 1'b0;
    rst_n   = 1'b0;
    pa      = 2'b11;
    pb      = 2'b11;
    mode    = 2'b10;
    cnt_clr = 2'b00;
    err_clr = 1'b0;
    hold(3);
    chk("reset count", count, 32'h0);
    chk("reset step", {30'b0, step}, 32'h0);
    chk("reset dir", {30'b0, dir}, 32'h0);
    chk("reset err", {30'b0, err}, 32'h0);
    chk("reset count_w", {28'b0, count_w}, 32'h0);

    // Release reset resting at 11: nothing may be counted or flagged.
    b0 = p0; b1 = p1;
    rst_n = 1'b1;
    hold(10);
    chk("rst11 pulses ch0", p0 - b0, 0);
    chk("rst11 pulses ch1", p1 - b1, 0);
    chk("rst11 err", {30'b0, err}, 32'h0);
    chk("rst11 count", count, 32'h0);

    // Re-home at 00 through reset.
    rst_n = 1'b0; pa = 2'b00; pb = 2'b00;
    hold(3);
    rst_n = 1'b1;
    hold(5);

    // x4 full CW cycle on channel 0, with latency check on the first step.
    b0 = p0; b1 = p1;
    set0(2'b10);
    hold(2);
    chk("x4 lat edge k+1", {31'b0, step[0]}, 32'h0);
    hold(1);
    chk("x4 lat edge k+2", {31'b0, step[0]}, 32'h1);
    chk("x4 count after 1", {16'b0, count[15:0]}, 32'h1);
    hold(1);
    chk("x4 pulse width", {31'b0, step[0]}, 32'h0);
    set0(2'b11); hold(4);
    set0(2'b01); hold(4);
    set0(2'b00); hold(4);
    chk("x4 pulses", p0 - b0, 4);
    chk("x4 dir", {31'b0, dir[0]}, 32'h1);
    chk("x4 count", {16'b0, count[15:0]}, 32'h4);
    chk("x4 ch1 untouched", {16'b0, count[31:16]}, 32'h0);
    chk("x4 ch1 pulses", p1 - b1, 0);

    // x1: clear, one full CCW cycle, then a bounce.
    mode = 2'b00;
    cnt_clr = 2'b01;
    hold(1);
    cnt_clr = 2'b00;
    chk("clr ch0", {16'b0, count[15:0]}, 32'h0);
    hold(2);
    b0 = p0;
    set0(2'b01); hold(4);
    set0(2'b11); hold(4);
    set0(2'b10); hold(4);
    set0(2'b00); hold(4);
    chk("x1 ccw pulses", p0 - b0, 1);
    chk("x1 ccw dir", {31'b0, dir[0]}, 32'h0);
    chk("x1 ccw count", {16'b0, count[15:0]}, 32'h0000FFFF);
    b0 = p0;
    set0(2'b10); hold(4);
    set0(2'b00); hold(4);
    chk("x1 bounce pulses", p0 - b0, 0);
    chk("x1 bounce count", {16'b0, count[15:0]}, 32'h0000FFFF);

    // x2: CW cycle counts on entry to 11 and 00.
    mode = 2'b01;
    hold(2);
    b0 = p0;
    set0(2'b10); hold(4);
    set0(2'b11); hold(4);
    set0(2'b01); hold(4);
    set0(2'b00); hold(4);
    chk("x2 pulses", p0 - b0, 2);
    chk("x2 count", {16'b0, count[15:0]}, 32'h1);
    chk("x2 dir", {31'b0, dir[0]}, 32'h1);

    // Illegal jumps 00->11->00, then error clear.
    b0 = p0;
    set0(2'b11); hold(4);
    chk("illegal err ch0", {31'b0, err[0]}, 32'h1);
    chk("illegal err ch1", {31'b0, err[1]}, 32'h0);
    chk("illegal count", {16'b0, count[15:0]}, 32'h1);
    set0(2'b00); hold(4);
    err_clr = 1'b1;
    hold(1);
    err_clr = 1'b0;
    chk("err cleared", {31'b0, err[0]}, 32'h0);
    chk("illegal no pulses", p0 - b0, 0);
    chk("illegal count kept", {16'b0, count[15:0]}, 32'h1);

    // Simultaneous CW steps on both channels while ch1 is held clear.
    mode = 2'b10;
    cnt_clr = 2'b11;
    hold(1);
    cnt_clr = 2'b10;
    chk("dual pre clear", count, 32'h0);
    pa = 2'b11; pb = 2'b00;
    hold(3);
    chk("dual step", {30'b0, step}, 32'h3);
    chk("dual dir", {30'b0, dir}, 32'h3);
    chk("dual ch0 count", {16'b0, count[15:0]}, 32'h1);
    chk("dual ch1 count", {16'b0, count[31:16]}, 32'h0);
    hold(1);
    cnt_clr = 2'b00;

    // 4-bit wrap vs saturate.
    rst_n = 1'b0; pa = 2'b00; pb = 2'b00;
    hold(3);
    rst_n = 1'b1;
    hold(5);
    bw = pw; bs = ps;
    set0(2'b10); hold(4);
    set0(2'b11); hold(4);
    set0(2'b01); hold(4);
    set0(2'b00); hold(4);
    set0(2'b10); hold(4);
    set0(2'b11); hold(4);
    set0(2'b01); hold(4);
    chk("w4 wrap at 7", {28'b0, count_w}, 32'h7);
    chk("w4 sat at 7", {28'b0, count_s}, 32'h7);
    set0(2'b00);
    hold(3);
    chk("w4 sat step pulse", {31'b0, step_s}, 32'h1);
    chk("w4 wrap to -8", {28'b0, count_w}, 32'h8);
    chk("w4 sat holds 7", {28'b0, count_s}, 32'h7);
    hold(1);
    chk("w4 sat pulses", ps - bs, 8);
    chk("w4 wrap pulses", pw - bw, 8);
    chk("w4 sat dir", {31'b0, dir_s}, 32'h1);
    set0(2'b01); hold(4);
    chk("w4 wrap ccw to 7", {28'b0, count_w}, 32'h7);
    chk("w4 sat ccw to 6", {28'b0, count_s}, 32'h6);
    chk("w4 wrap dir ccw", {31'b0, dir_w}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_encoder_counter.md
QUAD_ENCODER_COUNTER -- requirements
Module: quad_encoder_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter CHANNELS, default 2, SHALL set the number of independent encoder channels (legal range 1..8).
REQ-003 Parameter CNT_WIDTH, default 16, SHALL set the width of each signed two's-complement position counter (legal range 4..32).
REQ-004 Parameter WRAP, default 1, SHALL select counter overflow behaviour: 1 = modular wrap, 0 = saturate.
REQ-005 i_clk  input  1  rising-edge clock.
REQ-006 i_rst_n  input  1  synchronous active-low reset.
REQ-007 i_phase_a  input  CHANNELS  asynchronous phase A, bit n = channel n.
REQ-008 i_phase_b  input  CHANNELS  asynchronous phase B, bit n = channel n.
REQ-009 i_mode  input  2  resolution: 00 = x1, 01 = x2, 10 = x4, 11 = treated as x4.
REQ-010 i_cnt_clr  input  CHANNELS  per-channel counter clear, level-sensitive.
REQ-011 i_err_clr  input  1  clears all error flags.
REQ-012 o_step  output  CHANNELS  one-cycle pulse per counted step.
REQ-013 o_dir  output  CHANNELS  direction of the last step: 1 = CW, 0 = CCW.
REQ-014 o_count  output  CHANNELS*CNT_WIDTH  position; channel n occupies bits [n*CNT_WIDTH +: CNT_WIDTH].
REQ-015 o_err  output  CHANNELS  sticky illegal-transition flag.

Function
REQ-016 Each channel SHALL pass {A,B} through a two-flop synchronizer and SHALL keep a previous-state register, P, of the synchronized value S.
REQ-017 The CW sequence SHALL be 00->10->11->01->00; the reverse sequence is CCW.
REQ-018 A change of S in which exactly one bit differs from P SHALL be a valid quarter step; S == P SHALL be idle.
REQ-019 A change of S in which both bits differ from P SHALL be illegal: o_err[n] is set, no step is counted, P is updated, and the x1 tracking state is invalidated.
REQ-020 In x4 mode, every valid quarter step SHALL count.
REQ-021 In x2 mode, only valid quarter steps that enter 00 or 11 SHALL count.
REQ-022 x1 mode tracking: on leaving 00 toward 10 or 01, the block SHALL record the exit state in a leave register marked valid.
REQ-023 x1 mode counting: on entering 00 from state E with a valid leave register, a step SHALL count only if E is the bitwise inverse of the leave state (entry from 01 = CW, entry from 10 = CCW); the leave register is then invalidated.
REQ-024 A return to 00 through the same state it left by (a bounce) SHALL not count.
REQ-025 A counted step SHALL register, at a single clock edge: o_step[n] = 1 for exactly one cycle, o_dir[n] = the step direction, and o_count channel n incremented for CW or decremented for CCW.
REQ-026 Latency: an input change that is stable before clock edge k SHALL produce the o_step pulse and the count update at edge k+2, so the pulse is visible in the cycle after edge k+2.
REQ-027 o_dir SHALL hold its value between steps.
REQ-028 WRAP=1: the counter SHALL wrap from max positive to min negative (CW) and from min negative to max positive (CCW).
REQ-029 WRAP=0: the counter SHALL hold at max positive / min negative; o_step and o_dir still update on a saturated step.
REQ-030 i_cnt_clr[n] = 1 SHALL set channel n's count to 0 on the next edge; if a step occurs in the same cycle, the clear wins, while o_step and o_dir still report that step.
REQ-031 i_err_clr = 1 SHALL clear all o_err bits; if an illegal transition occurs in the same cycle, the set wins for that channel.
REQ-032 Any change of i_mode SHALL invalidate every channel's x1 leave register on the next edge; the new mode applies to decisions made from that edge onward.
REQ-033 Channels SHALL be fully independent; simultaneous steps on different channels SHALL each be counted.

Reset
REQ-034 While i_rst_n = 0 at an edge, the block SHALL clear: synchronizers, P, leave registers (to invalid), o_step, o_dir, o_count, and o_err.
REQ-035 After reset release, decode SHALL be suppressed for the first 3 edges while P is loaded from S, so that a non-00 resting input produces neither a step nor an error.
REQ-036 Reset asserted mid-rotation SHALL discard the partial x1 cycle.

Verification
REQ-037 x4 mode, channel 0 driven one full CW cycle 00->10->11->01->00, each state held 4 cycles -> 4 o_step pulses, o_dir=1, count 0->4.
REQ-038 x1 mode, one full CCW cycle, then a bounce 00->10->00 -> exactly 1 pulse with o_dir=0 and count=-1; the bounce adds no count.
REQ-039 Direct 00->11 jump -> o_err[0]=1 with count unchanged; then i_err_clr pulsed -> o_err[0]=0.
REQ-040 CNT_WIDTH=4: from 7, one CW step -> WRAP=1 gives -8, WRAP=0 holds at 7 with o_step still pulsing.
REQ-041 Reset released with inputs at 11 -> no step and no error during the following 10 cycles.
REQ-042 CHANNELS=2, both channels stepping CW on the same edge while i_cnt_clr[1]=1 -> ch0 = 1, ch1 = 0, both o_step bits = 1.
